// File: rtl/cpu_pkg.sv
// Shared definitions for the decode-stage hazard controller.
//   NOOP      : instruction substituted into decode when a bubble is injected
//   BR_OPC    : value of instr[28:26] identifying the branch class
//   ZERO_REG  : register index 31 (XZR), never a real load destination
//   state_t   : hazard controller FSM states
//   is_branch : branch-class decode helper
package cpu_pkg;

    localparam logic [31:0] NOOP     = 32'h910003FF;  // ADDI X31,X31,#0
    localparam logic [2:0]  BR_OPC   = 3'b101;        // B, BL, CBZ, CBNZ, B.cond
    localparam logic [4:0]  ZERO_REG = 5'd31;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        BR_WAIT  = 2'd2
    } state_t;

    function automatic logic is_branch(input logic [2:0] opc_field);
        return (opc_field == BR_OPC);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline and the hazard controller.
//   instr_id    : instruction in the IF/ID register
//   ex_mem_read : EX-stage instruction is a load
//   ex_rd       : EX-stage destination register
//   flush       : one-cycle squash request
//   pc_we       : PC write enable
//   ifid_we     : IF/ID write enable
//   instr_out   : instruction forwarded to decode (instr_id or NOOP)
//   stall_cnt   : saturating count of NOOP-injected cycles
// master = pipeline side (drives instr/EX info), slave = controller side.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      instr_id;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             flush;
    logic             pc_we;
    logic             ifid_we;
    logic [31:0]      instr_out;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output instr_id, ex_mem_read, ex_rd, flush,
        input  pc_we, ifid_we, instr_out, stall_cnt
    );

    modport slave (
        input  instr_id, ex_mem_read, ex_rd, flush,
        output pc_we, ifid_we, instr_out, stall_cnt
    );
endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detector.
//   i_mem_read : EX-stage instruction is a load
//   i_rd       : EX-stage destination register
//   i_rn/i_rm/i_rt : register fields of the decode instruction
//   o_hazard   : decode instruction may read the loaded register
// All three fields are compared regardless of format; an occasional
// false stall is cheaper than decoding which fields are real sources.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic       i_mem_read,
    input  logic [4:0] i_rd,
    input  logic [4:0] i_rn,
    input  logic [4:0] i_rm,
    input  logic [4:0] i_rt,
    output logic       o_hazard
);
    logic w_match;

    assign w_match  = (i_rd == i_rn) || (i_rd == i_rm) || (i_rd == i_rt);
    assign o_hazard = i_mem_read && (i_rd != ZERO_REG) && w_match;
endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: one-cycle load-use stall, NOOP bubbles
// after a branch leaves decode, and flush squashing.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : instr_id/ex_mem_read/ex_rd/flush in,
//                  pc_we/ifid_we/instr_out/stall_cnt out
// Parameters: BR_BUBBLES (1..7) bubbles after a branch, CNT_W counter width.
// pc_we, ifid_we and instr_out are Mealy outputs so a hazard stalls in
// the same cycle it is seen.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int BR_BUBBLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    hazard_ctrl_if.slave  bus
);
    localparam logic [2:0] BUB_INIT = 3'(BR_BUBBLES);

    state_t           r_state;
    logic [2:0]       r_bub;
    logic [CNT_W-1:0] r_stall_cnt;

    state_t           w_state_nxt;
    logic [2:0]       w_bub_nxt;
    logic             w_hazard;
    logic             w_branch;
    logic             w_inject;
    logic             w_pc_we;
    logic             w_ifid_we;

    hazard_detect u_hazard_detect (
        .i_mem_read (bus.ex_mem_read),
        .i_rd       (bus.ex_rd),
        .i_rn       (bus.instr_id[9:5]),
        .i_rm       (bus.instr_id[20:16]),
        .i_rt       (bus.instr_id[4:0]),
        .o_hazard   (w_hazard)
    );

    assign w_branch = is_branch(bus.instr_id[28:26]);

    always_comb begin
        w_pc_we     = 1'b1;
        w_ifid_we   = 1'b1;
        w_inject    = 1'b0;
        w_state_nxt = r_state;
        w_bub_nxt   = r_bub;

        if (bus.flush) begin
            w_inject    = 1'b1;
            w_state_nxt = RUN;
            w_bub_nxt   = 3'd0;
        end else begin
            case (r_state)
                RUN: begin
                    // Load-use outranks branch: the branch is replayed next cycle.
                    if (w_hazard) begin
                        w_pc_we     = 1'b0;
                        w_ifid_we   = 1'b0;
                        w_inject    = 1'b1;
                        w_state_nxt = LD_STALL;
                    end else if (w_branch) begin
                        w_state_nxt = BR_WAIT;
                        w_bub_nxt   = BUB_INIT;
                    end
                end
                LD_STALL: begin
                    // The held instruction now issues; hazard check is skipped so
                    // the stall lasts one cycle, but a branch still needs bubbles.
                    if (w_branch) begin
                        w_state_nxt = BR_WAIT;
                        w_bub_nxt   = BUB_INIT;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
                BR_WAIT: begin
                    // Whatever is in decode (including another branch) is squashed.
                    w_inject  = 1'b1;
                    w_bub_nxt = r_bub - 3'd1;
                    if (r_bub <= 3'd1) begin
                        w_state_nxt = RUN;
                        w_bub_nxt   = 3'd0;
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                    w_bub_nxt   = 3'd0;
                end
            endcase
        end
    end

    // Reset forces the safe output values combinationally, not just via state.
    assign bus.pc_we     = w_pc_we & reset_n;
    assign bus.ifid_we   = w_ifid_we & reset_n;
    assign bus.instr_out = (w_inject || !reset_n) ? NOOP : bus.instr_id;
    assign bus.stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= RUN;
            r_bub       <= 3'd0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bub   <= w_bub_nxt;
            if (w_inject && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    import cpu_pkg::*;

    localparam logic [31:0] ADD_I = 32'h8B030022;  // ADD X2,X1,X3
    localparam logic [31:0] B_I   = 32'h14000004;  // B
    localparam logic [31:0] CBZ_I = 32'hB4000041;  // CBZ X1

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(16)) if0 ();
    hazard_ctrl_if #(.CNT_W(4))  if1 ();

    hazard_ctrl #(.BR_BUBBLES(1), .CNT_W(16)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(if0.slave));
    hazard_ctrl #(.BR_BUBBLES(3), .CNT_W(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1.slave));

    typedef struct {
        logic        pc_we;
        logic        ifid_we;
        logic [31:0] instr;
        int unsigned scnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int checks = 0;
    int errors = 0;

    // Reference model: bubbles still owed, whether the previous cycle was a
    // load stall, and the injected-NOOP tally.
    int          m_bub[2];
    bit          m_just[2];
    int unsigned m_scnt[2];

    function automatic exp_t model(int k, logic rn, logic [31:0] ins,
                                   logic mr, logic [4:0] rd, logic fl);
        exp_t e;
        int unsigned br   = (k == 0) ? 1 : 3;
        int unsigned cmax = (k == 0) ? 65535 : 15;
        bit hz, brc, inj;
        if (!rn) begin
            m_bub[k] = 0; m_just[k] = 0; m_scnt[k] = 0;
            e.pc_we = 0; e.ifid_we = 0; e.instr = NOOP; e.scnt = 0;
            return e;
        end
        e.scnt = m_scnt[k];
        hz  = mr && (rd != 5'd31) &&
              (rd == ins[9:5] || rd == ins[20:16] || rd == ins[4:0]);
        brc = (ins[28:26] == 3'b101);
        e.pc_we = 1; e.ifid_we = 1; inj = 0;
        if (fl) begin
            inj = 1; m_bub[k] = 0; m_just[k] = 0;
        end else if (m_bub[k] > 0) begin
            inj = 1; m_bub[k]--; m_just[k] = 0;
        end else if (!m_just[k] && hz) begin
            inj = 1; e.pc_we = 0; e.ifid_we = 0; m_just[k] = 1;
        end else begin
            m_bub[k] = brc ? int'(br) : 0; m_just[k] = 0;
        end
        e.instr = inj ? NOOP : ins;
        if (inj && m_scnt[k] < cmax) m_scnt[k]++;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUTs present against queued expectations.
    always @(negedge clk) begin
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            chk("d0.pc_we",     {31'b0, if0.pc_we},   {31'b0, e0.pc_we});
            chk("d0.ifid_we",   {31'b0, if0.ifid_we}, {31'b0, e0.ifid_we});
            chk("d0.instr_out", if0.instr_out,        e0.instr);
            chk("d0.stall_cnt", 32'(if0.stall_cnt),   e0.scnt);
        end
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            chk("d1.pc_we",     {31'b0, if1.pc_we},   {31'b0, e1.pc_we});
            chk("d1.ifid_we",   {31'b0, if1.ifid_we}, {31'b0, e1.ifid_we});
            chk("d1.instr_out", if1.instr_out,        e1.instr);
            chk("d1.stall_cnt", 32'(if1.stall_cnt),   e1.scnt);
        end
    end

    task automatic step(logic rn, logic [31:0] ins, logic mr, logic [4:0] rd, logic fl);
        @(posedge clk);
        #1;
        reset_n = rn;
        if0.instr_id = ins; if0.ex_mem_read = mr; if0.ex_rd = rd; if0.flush = fl;
        if1.instr_id = ins; if1.ex_mem_read = mr; if1.ex_rd = rd; if1.flush = fl;
        q0.push_back(model(0, rn, ins, mr, rd, fl));
        q1.push_back(model(1, rn, ins, mr, rd, fl));
    endtask

    task automatic do_reset();
        step(1'b0, ADD_I, 1'b0, 5'd0, 1'b0);
        step(1'b0, ADD_I, 1'b0, 5'd0, 1'b0);
    endtask

    function automatic logic [4:0] rreg();
        int unsigned r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        logic [31:0] ins;
        reset_n = 1'b0;
        if0.instr_id = ADD_I; if0.ex_mem_read = 0; if0.ex_rd = 0; if0.flush = 0;
        if1.instr_id = ADD_I; if1.ex_mem_read = 0; if1.ex_rd = 0; if1.flush = 0;
        do_reset();

        // Load-use on ADD X2,X1,X3
        step(1, ADD_I, 1, 5'd1, 0);
        step(1, ADD_I, 0, 5'd0, 0);
        step(1, ADD_I, 0, 5'd0, 0);

        // Plain branch followed by filler
        do_reset();
        step(1, B_I, 0, 5'd0, 0);
        for (int i = 0; i < 4; i++) step(1, ADD_I, 0, 5'd0, 0);

        // CBZ with a load-use hazard, then branch bubbles
        do_reset();
        step(1, CBZ_I, 1, 5'd1, 0);
        step(1, CBZ_I, 0, 5'd0, 0);
        for (int i = 0; i < 4; i++) step(1, ADD_I, 0, 5'd0, 0);

        // Flush together with a load-use hazard
        step(1, ADD_I, 1, 5'd1, 1);
        step(1, ADD_I, 0, 5'd0, 0);

        // Branch during BR_WAIT is squashed and does not extend it
        step(1, B_I, 0, 5'd0, 0);
        step(1, B_I, 0, 5'd0, 0);
        for (int i = 0; i < 4; i++) step(1, ADD_I, 0, 5'd0, 0);

        // Reset dropped mid BR_WAIT
        step(1, B_I, 0, 5'd0, 0);
        step(1, ADD_I, 0, 5'd0, 0);
        step(0, ADD_I, 0, 5'd0, 0);
        step(1, ADD_I, 0, 5'd0, 0);
        step(1, ADD_I, 0, 5'd0, 0);

        // Saturation with 20 flushes
        do_reset();
        for (int i = 0; i < 20; i++) step(1, ADD_I, 0, 5'd0, 1);
        step(1, ADD_I, 0, 5'd0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            ins = $urandom;
            ins[4:0]   = rreg();
            ins[9:5]   = rreg();
            ins[20:16] = rreg();
            if ($urandom_range(0, 3) == 0) ins[28:26] = 3'b101;
            else if (ins[28:26] == 3'b101) ins[26] = 1'b0;
            if (ins == NOOP) ins[0] = ~ins[0];
            step(($urandom_range(0, 99) != 0), ins, 1'($urandom_range(0, 1)),
                 rreg(), ($urandom_range(0, 9) == 0));
        end

        @(negedge clk);
        #1;
        chk("queue_drain", 32'(q0.size() + q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
